// File: rtl/iob_eth_tx_dma_pkg.sv
// Shared definitions for the Ethernet TX read-DMA: FSM encoding and AXI4 constants.
package iob_eth_tx_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_DATA   = 3'd2,
    ST_UNPACK = 3'd3,
    ST_DONE   = 3'd4
  } dma_state_t;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [3:0] AXI_CACHE_DEF   = 4'b0011;

  // AXI bursts may not cross a 4 KB page
  localparam int BOUNDARY_W = 12;

endpackage

// File: rtl/iob_eth_burst_calc.sv
// Combinational burst sizing: beats = min(words_left, MAX_BURST, words to next 4 KB page).
module iob_eth_burst_calc
  import iob_eth_tx_dma_pkg::*;
#(
  parameter int WL_W      = 12,
  parameter int NB_LOG2   = 2,
  parameter int MAX_BURST = 16
) (
  input  logic [BOUNDARY_W-1:0] addr_low,
  input  logic [WL_W-1:0]       words_left,
  output logic [8:0]            beats,
  output logic [7:0]            arlen
);

  localparam int CW = (WL_W > BOUNDARY_W + 1) ? WL_W : BOUNDARY_W + 1;

  logic [CW-1:0] to_bound_s, wl_s, mb_s, min1_s, beats_full_s;

  // minimum of the three burst limits
  always_comb begin
    to_bound_s = CW'(({1'b1, {BOUNDARY_W{1'b0}}} - {1'b0, addr_low}) >> NB_LOG2);
    wl_s       = CW'(words_left);
    mb_s       = CW'(MAX_BURST);
    if (wl_s < mb_s) begin
      min1_s = wl_s;
    end else begin
      min1_s = mb_s;
    end
    if (to_bound_s < min1_s) begin
      beats_full_s = to_bound_s;
    end else begin
      beats_full_s = min1_s;
    end
  end

  assign beats = 9'(beats_full_s);
  assign arlen = 8'(beats_full_s - CW'(1));

endmodule

// File: rtl/iob_eth_tx_dma.sv
// AXI4 read-master DMA: fetches a frame from memory and writes it byte-wise into the TX buffer.
module iob_eth_tx_dma
  import iob_eth_tx_dma_pkg::*;
#(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int BUF_ADDR_W = 11,
  parameter int MAX_BURST  = 16
) (
  input  logic                  clk,
  input  logic                  rst_int,
  input  logic [AXI_ADDR_W-1:0] dma_addr,
  input  logic [BUF_ADDR_W-1:0] dma_nbytes,
  input  logic [BUF_ADDR_W-1:0] dma_start_index,
  input  logic                  dma_run,
  output logic                  dma_ready,
  output logic                  dma_error,
  output logic [BUF_ADDR_W-1:0] buf_addr,
  output logic [7:0]            buf_data,
  output logic                  buf_we,
  output logic                  m_axi_arid,
  output logic [AXI_ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic [3:0]            m_axi_arqos,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic                  m_axi_rid,
  input  logic [AXI_DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam int NB      = AXI_DATA_W / 8;
  localparam int NB_LOG2 = $clog2(NB);
  localparam int WL_W    = BUF_ADDR_W + 1;

  dma_state_t            state_r, state_s;
  logic [AXI_ADDR_W-1:0] addr_r;
  logic [WL_W-1:0]       words_left_r;
  logic [BUF_ADDR_W-1:0] bytes_left_r, wr_ptr_r, buf_addr_r;
  logic [AXI_DATA_W-1:0] shift_r;
  logic [NB_LOG2-1:0]    byte_cnt_r;
  logic                  last_r, error_r, buf_we_r;
  logic [7:0]            buf_data_r, arlen_s;
  logic [8:0]            beats_s;
  logic                  byte_last_s;
  logic                  unused_s;

  assign byte_last_s = (byte_cnt_r == NB_LOG2'(NB - 1));
  assign unused_s    = m_axi_rid ^ (^dma_addr[NB_LOG2-1:0]);

  iob_eth_burst_calc #(
    .WL_W     (WL_W),
    .NB_LOG2  (NB_LOG2),
    .MAX_BURST(MAX_BURST)
  ) u_burst_calc (
    .addr_low  (addr_r[BOUNDARY_W-1:0]),
    .words_left(words_left_r),
    .beats     (beats_s),
    .arlen     (arlen_s)
  );

  // state register
  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (dma_run) begin
          state_s = (dma_nbytes == BUF_ADDR_W'(0)) ? ST_DONE : ST_ADDR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (m_axi_arready) begin
          state_s = ST_DATA;
        end else begin
          state_s = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (m_axi_rvalid) begin
          state_s = ST_UNPACK;
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_UNPACK: begin
        if (!byte_last_s) begin
          state_s = ST_UNPACK;
        end else if (!last_r) begin
          state_s = ST_DATA;
        end else if (words_left_r != WL_W'(0)) begin
          state_s = ST_ADDR;
        end else begin
          state_s = ST_DONE;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // transfer bookkeeping, beat capture and little-endian byte unpacking
  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      addr_r       <= '0;
      words_left_r <= '0;
      bytes_left_r <= '0;
      wr_ptr_r     <= '0;
      shift_r      <= '0;
      byte_cnt_r   <= '0;
      last_r       <= 1'b0;
      error_r      <= 1'b0;
      buf_we_r     <= 1'b0;
      buf_addr_r   <= '0;
      buf_data_r   <= 8'd0;
    end else begin
      buf_we_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (dma_run) begin
            addr_r       <= {dma_addr[AXI_ADDR_W-1:NB_LOG2], {NB_LOG2{1'b0}}};
            words_left_r <= (WL_W'(dma_nbytes) + WL_W'(NB - 1)) >> NB_LOG2;
            bytes_left_r <= dma_nbytes;
            wr_ptr_r     <= dma_start_index;
            error_r      <= 1'b0;
          end
        end
        ST_ADDR: begin
          if (m_axi_arready) begin
            addr_r       <= addr_r + (AXI_ADDR_W'(beats_s) << NB_LOG2);
            words_left_r <= words_left_r - WL_W'(beats_s);
          end
        end
        ST_DATA: begin
          if (m_axi_rvalid) begin
            shift_r    <= m_axi_rdata;
            last_r     <= m_axi_rlast;
            byte_cnt_r <= '0;
            if (m_axi_rresp != AXI_RESP_OKAY) begin
              error_r <= 1'b1;
            end
          end
        end
        ST_UNPACK: begin
          shift_r    <= shift_r >> 8;
          byte_cnt_r <= byte_cnt_r + NB_LOG2'(1);
          // padding bytes past the frame end are skipped
          if (bytes_left_r != BUF_ADDR_W'(0)) begin
            buf_we_r     <= 1'b1;
            buf_data_r   <= shift_r[7:0];
            buf_addr_r   <= wr_ptr_r;
            wr_ptr_r     <= wr_ptr_r + BUF_ADDR_W'(1);
            bytes_left_r <= bytes_left_r - BUF_ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign dma_ready     = (state_r == ST_IDLE);
  assign dma_error     = error_r;
  assign buf_addr      = buf_addr_r;
  assign buf_data      = buf_data_r;
  assign buf_we        = buf_we_r;
  assign m_axi_arid    = 1'b0;
  assign m_axi_araddr  = addr_r;
  assign m_axi_arlen   = (state_r == ST_ADDR) ? arlen_s : 8'd0;
  assign m_axi_arsize  = 3'(NB_LOG2);
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = AXI_CACHE_DEF;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arqos   = 4'd0;
  assign m_axi_arvalid = (state_r == ST_ADDR);
  assign m_axi_rready  = (state_r == ST_DATA);

endmodule

// File: tb/tb_iob_eth_tx_dma.sv
// Directed bench for iob_eth_tx_dma: AXI read-slave model with scoreboards for AR requests and buffer writes.
module tb_iob_eth_tx_dma;

  logic        clk = 1'b0;
  logic        rst_int;
  logic [31:0] dma_addr;
  logic [10:0] dma_nbytes, dma_start_index;
  logic        dma_run, dma_ready, dma_error;
  logic [10:0] buf_addr;
  logic [7:0]  buf_data;
  logic        buf_we;
  logic        m_axi_arid, m_axi_arlock, m_axi_arvalid, m_axi_arready;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize, m_axi_arprot;
  logic [1:0]  m_axi_arburst, m_axi_rresp;
  logic [3:0]  m_axi_arcache, m_axi_arqos;
  logic        m_axi_rid, m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic [31:0] m_axi_rdata;

  iob_eth_tx_dma dut (
    .clk(clk), .rst_int(rst_int), .dma_addr(dma_addr), .dma_nbytes(dma_nbytes),
    .dma_start_index(dma_start_index), .dma_run(dma_run), .dma_ready(dma_ready),
    .dma_error(dma_error), .buf_addr(buf_addr), .buf_data(buf_data), .buf_we(buf_we),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_rid(m_axi_rid),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0, last_we_cyc = 0, wr_cnt = 0, ar_cnt = 0;
  int beat_total = 0, err_beat = -1;
  bit stall_en = 1'b0;
  logic [39:0] exp_ar_q[$];   // {araddr, arlen}
  logic [18:0] exp_wr_q[$];   // {buf_addr, buf_data}

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic flag(input string tag);
    n_checks++;
    n_errors++;
    $error("FAIL %s: observed=unexpected event expected=none", tag);
  endtask

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [7:0] t;
    t = a[7:0] * 8'd7;
    return t ^ a[15:8] ^ 8'h3C;
  endfunction

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  // AXI read slave: one burst at a time, optional random stalls and error injection
  logic [31:0] b_addr, pend_addr, ba;
  logic [7:0]  pend_len;
  int          b_len, b_beat;
  bit          b_active = 1'b0, ar_pend = 1'b0, r_pend = 1'b0;
  logic [39:0] ear;
  initial begin
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = 32'd0;
    m_axi_rresp = 2'b00; m_axi_rlast = 1'b0; m_axi_rid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_int) begin
        b_active = 1'b0; ar_pend = 1'b0; r_pend = 1'b0;
        m_axi_rvalid = 1'b0; m_axi_arready = 1'b0; m_axi_rlast = 1'b0;
      end else begin
        if (ar_pend) begin
          ar_cnt++;
          if (exp_ar_q.size() == 0) flag("ar_unexpected");
          else begin
            ear = exp_ar_q.pop_front();
            check("ar_addr", 64'(pend_addr), 64'(ear[39:8]));
            check("ar_len", 64'(pend_len), 64'(ear[7:0]));
          end
          b_active = 1'b1; b_addr = pend_addr; b_len = int'(pend_len); b_beat = 0;
          m_axi_rvalid = 1'b0;
        end
        if (r_pend) begin
          b_beat++; beat_total++;
          m_axi_rvalid = 1'b0;
          if (b_beat > b_len) b_active = 1'b0;
        end
        m_axi_arready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        if (b_active && !m_axi_rvalid && (!stall_en || $urandom_range(0, 2) != 0)) begin
          ba = b_addr + 32'(b_beat * 4);
          m_axi_rdata  = {mem_byte(ba + 32'd3), mem_byte(ba + 32'd2), mem_byte(ba + 32'd1), mem_byte(ba)};
          m_axi_rresp  = (beat_total == err_beat) ? 2'b10 : 2'b00;
          m_axi_rlast  = (b_beat == b_len);
          m_axi_rvalid = 1'b1;
        end
        ar_pend = m_axi_arvalid && m_axi_arready;
        pend_addr = m_axi_araddr; pend_len = m_axi_arlen;
        r_pend = m_axi_rvalid && m_axi_rready;
      end
    end
  end

  // buffer write monitor against the expected-write scoreboard
  initial forever begin
    @(negedge clk);
    cyc++;
    if (buf_we === 1'b1) begin
      wr_cnt++;
      last_we_cyc = cyc;
      if (exp_wr_q.size() == 0) flag("wr_unexpected");
      else check("wr_addr_data", 64'({buf_addr, buf_data}), 64'(exp_wr_q.pop_front()));
    end
  end

  task automatic push_wr(input logic [31:0] a, input int n, input int s);
    for (int i = 0; i < n; i++) exp_wr_q.push_back({11'(s + i), mem_byte(a + 32'(i))});
  endtask

  task automatic start_run(input logic [31:0] a, input logic [10:0] n, input logic [10:0] s);
    check("ready_idle", 64'(dma_ready), 64'd1);
    beat_total = 0;
    dma_addr = a; dma_nbytes = n; dma_start_index = s; dma_run = 1'b1;
    tick;
    dma_run = 1'b0;
    check("ready_drop", 64'(dma_ready), 64'd0);
  endtask

  task automatic wait_done(input bit chk_we_edge);
    int n = 0;
    while (dma_ready !== 1'b1 && n < 3000) begin tick; n++; end
    check("ready_done", 64'(dma_ready), 64'd1);
    check("wr_left", 64'(exp_wr_q.size()), 64'd0);
    check("ar_left", 64'(exp_ar_q.size()), 64'd0);
    if (chk_we_edge) check("ready_after_we", 64'(cyc - last_we_cyc), 64'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, 64'(dma_ready), 64'd1);
    check({tag, "_error"}, 64'(dma_error), 64'd0);
    check({tag, "_we"}, 64'(buf_we), 64'd0);
    check({tag, "_baddr"}, 64'(buf_addr), 64'd0);
    check({tag, "_bdata"}, 64'(buf_data), 64'd0);
    check({tag, "_arvalid"}, 64'(m_axi_arvalid), 64'd0);
    check({tag, "_rready"}, 64'(m_axi_rready), 64'd0);
    check({tag, "_araddr"}, 64'(m_axi_araddr), 64'd0);
    check({tag, "_arlen"}, 64'(m_axi_arlen), 64'd0);
    check({tag, "_const"}, 64'({m_axi_arid, m_axi_arsize, m_axi_arburst, m_axi_arlock,
                                m_axi_arcache, m_axi_arprot, m_axi_arqos}),
          64'({1'b0, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000, 4'd0}));
  endtask

  int wr0, ar0, low, n;
  initial begin
    rst_int = 1'b1; dma_run = 1'b0; dma_addr = 32'd0; dma_nbytes = 11'd0; dma_start_index = 11'd0;
    #1;
    check_reset_vals("rst");
    tick; tick;
    rst_int = 1'b0;
    tick;

    // single burst, partial last word
    exp_ar_q.push_back({32'h100, 8'd11});
    push_wr(32'h100, 46, 0);
    wr0 = wr_cnt;
    start_run(32'h100, 11'd46, 11'd0);
    wait_done(1'b0);
    check("t1_wr_cnt", 64'(wr_cnt - wr0), 64'd46);
    check("t1_error", 64'(dma_error), 64'd0);

    // two bursts
    exp_ar_q.push_back({32'h2000, 8'd15});
    exp_ar_q.push_back({32'h2040, 8'd8});
    push_wr(32'h2000, 100, 100);
    wr0 = wr_cnt;
    start_run(32'h2000, 11'd100, 11'd100);
    wait_done(1'b1);
    check("t2_wr_cnt", 64'(wr_cnt - wr0), 64'd100);

    // 4 KB boundary split
    exp_ar_q.push_back({32'h0FF8, 8'd1});
    exp_ar_q.push_back({32'h1000, 8'd1});
    push_wr(32'h0FF8, 16, 300);
    start_run(32'h0FF8, 11'd16, 11'd300);
    wait_done(1'b1);

    // zero-length run
    wr0 = wr_cnt; ar0 = ar_cnt;
    start_run(32'h500, 11'd0, 11'd0);
    low = 1; n = 0;
    while (dma_ready !== 1'b1 && n < 10) begin tick; low++; n++; end
    check("t4_low_cycles_ok", 64'(low >= 1 && low <= 2), 64'd1);
    tick; tick;
    check("t4_no_wr", 64'(wr_cnt - wr0), 64'd0);
    check("t4_no_ar", 64'(ar_cnt - ar0), 64'd0);

    // buffer wrap with stalls; a run pulse mid-transfer must be ignored
    stall_en = 1'b1;
    exp_ar_q.push_back({32'h300, 8'd2});
    push_wr(32'h300, 12, 2040);
    start_run(32'h303, 11'd12, 11'd2040);
    tick; tick;
    dma_addr = 32'h900; dma_nbytes = 11'd4; dma_start_index = 11'd0; dma_run = 1'b1;
    tick;
    dma_run = 1'b0;
    wait_done(1'b0);

    // slave error on the third beat
    err_beat = 2;
    exp_ar_q.push_back({32'h400, 8'd9});
    push_wr(32'h400, 40, 500);
    wr0 = wr_cnt;
    start_run(32'h400, 11'd40, 11'd500);
    wait_done(1'b1);
    err_beat = -1;
    check("t6_error_set", 64'(dma_error), 64'd1);
    check("t6_wr_cnt", 64'(wr_cnt - wr0), 64'd40);
    stall_en = 1'b0;
    exp_ar_q.push_back({32'h500, 8'd1});
    push_wr(32'h500, 8, 600);
    start_run(32'h500, 11'd8, 11'd600);
    check("t6_error_clr", 64'(dma_error), 64'd0);
    wait_done(1'b1);
    check("t6_error_final", 64'(dma_error), 64'd0);

    // asynchronous reset mid-burst
    exp_ar_q.push_back({32'h600, 8'd15});
    push_wr(32'h600, 64, 0);
    wr0 = wr_cnt;
    start_run(32'h600, 11'd64, 11'd0);
    n = 0;
    while (wr_cnt - wr0 < 5 && n < 500) begin tick; n++; end
    check("t7_progress", 64'(wr_cnt - wr0 >= 5), 64'd1);
    #2;
    rst_int = 1'b1;
    #1;
    check_reset_vals("midrst");
    tick;
    exp_wr_q.delete();
    exp_ar_q.delete();
    rst_int = 1'b0;
    tick;

    // recovery after reset
    exp_ar_q.push_back({32'h700, 8'd1});
    push_wr(32'h700, 8, 10);
    start_run(32'h700, 11'd8, 11'd10);
    wait_done(1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
